// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and helpers for the MEM-stage data-memory responder.
//   state_t      : responder FSM states (IDLE, WAIT, RESP)
//   DATA_W       : data word width (32)
//   BE_W         : byte-enable width / bytes per word (4)
//   CNT_W        : wait-state counter width (4, so 0..15 wait states)
//   byte_parity  : per-byte even-parity bits of a data word
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit i is the XOR of byte i, i.e. the bit that makes that byte plus its
  // parity bit contain an even number of ones.
  function automatic logic [BE_W-1:0] byte_parity(input logic [DATA_W-1:0] data);
    logic [BE_W-1:0] p;
    for (int i = 0; i < BE_W; i++) begin
      p[i] = ^data[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/dmem_responder.sv
// dmem_responder -- responder end of the MEM-stage data-memory interface.
// Owns the data RAM and services one load or store per request after
// WAIT_CYCLES wait states, presenting a one-cycle response pulse and
// stalling the upstream pipeline while the request is outstanding.
//
// Parameters:
//   ADDR_W      : word-address width, RAM depth 2**ADDR_W words
//   WAIT_CYCLES : wait states per access (0..15)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request present          req_ready : can accept this cycle
//   req_we      : 1 = store, 0 = load      req_addr  : word address
//   req_be      : store byte enables       req_wdata : store data
//   rsp_valid   : one-cycle response pulse rsp_rdata : load data (held)
//   rsp_err     : load parity error        stall     : freeze upstream pipeline
// Optional build macro:
//   DMEM_PARITY_EN : adds per-byte even-parity storage and load error
//                    detection; when undefined rsp_err is constant 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter preload on acceptance: WAIT is left when the counter reads 0,
  // so loading WAIT_CYCLES-1 gives exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [BE_W-1:0]    be_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               err_reg;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Fields of the request committed on the coming edge. With zero wait
  // states the commit edge is the acceptance edge, so the live request
  // inputs are used; otherwise the latched copy is used.
  logic               accept;
  logic               commit;
  logic               c_we;
  logic [ADDR_W-1:0]  c_addr;
  logic [BE_W-1:0]    c_be;
  logic [DATA_W-1:0]  c_wdata;
  logic               load_err;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    c_we       = we_reg;
    c_addr     = addr_reg;
    c_be       = be_reg;
    c_wdata    = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          c_we    = req_we;
          c_addr  = req_addr;
          c_be    = req_be;
          c_wdata = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  // Dropped in RESP so the pipeline advances while the response is presented.
  assign stall     = ((state_reg == IDLE) && req_valid) || (state_reg == WAIT);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

`ifdef DMEM_PARITY_EN
  // Packed so a single entry can be overridden from outside for error injection.
  logic [DEPTH-1:0][BE_W-1:0] par_mem;

  assign load_err = |(par_mem[c_addr] ^ byte_parity(mem[c_addr]));
`else
  assign load_err = 1'b0;
`endif

  // RAM write port; rst_n gates the write so no store commits while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && commit && c_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (c_be[i]) begin
          mem[c_addr][8*i +: 8] <= c_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
          par_mem[c_addr][i] <= ^c_wdata[8*i +: 8];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        be_reg    <= req_be;
        wdata_reg <= req_wdata;
      end
      // Read data is held until the next load commit; the error flag lives
      // only for the RESP cycle.
      if (commit && !c_we) begin
        rdata_reg <= mem[c_addr];
        err_reg   <= load_err;
      end else if (state_reg == RESP) begin
        err_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed bench for dmem_responder.
// Instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        rq_valid [2];
  logic        rq_ready [2];
  logic        rq_we    [2];
  logic [8:0]  rq_addr  [2];
  logic [3:0]  rq_be    [2];
  logic [31:0] rq_wdata [2];
  logic        rs_valid [2];
  logic [31:0] rs_rdata [2];
  logic        rs_err   [2];
  logic        rq_stall [2];

  int tests_run;
  int tests_failed;

  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rq_valid[0]), .req_ready(rq_ready[0]), .req_we(rq_we[0]),
    .req_addr(rq_addr[0]), .req_be(rq_be[0]), .req_wdata(rq_wdata[0]),
    .rsp_valid(rs_valid[0]), .rsp_rdata(rs_rdata[0]), .rsp_err(rs_err[0]),
    .stall(rq_stall[0])
  );

  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rq_valid[1]), .req_ready(rq_ready[1]), .req_we(rq_we[1]),
    .req_addr(rq_addr[1]), .req_be(rq_be[1]), .req_wdata(rq_wdata[1]),
    .rsp_valid(rs_valid[1]), .rsp_rdata(rs_rdata[1]), .rsp_err(rs_err[1]),
    .stall(rq_stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request to instance idx, starting just after a rising edge
  // with the instance idle. Returns cycles from acceptance to rsp_valid,
  // cycles with stall high, and the response data/error seen in RESP.
  task automatic issue(input int idx, input logic we, input logic [8:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       output int lat, output int stalls,
                       output logic [31:0] rdata, output logic err);
    rq_valid[idx] = 1'b1;
    rq_we[idx]    = we;
    rq_addr[idx]  = addr;
    rq_be[idx]    = be;
    rq_wdata[idx] = wd;
    lat = 0;
    stalls = 0;
    rdata = 'x;
    err = 1'bx;
    @(negedge clk);
    if (rq_stall[idx]) stalls++;
    @(posedge clk);
    #1;
    // Scramble the request inputs: the latched copy must be used.
    rq_valid[idx] = 1'b0;
    rq_we[idx]    = ~we;
    rq_addr[idx]  = ~addr;
    rq_be[idx]    = ~be;
    rq_wdata[idx] = ~wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rq_stall[idx]) stalls++;
      if (rs_valid[idx]) begin
        rdata = rs_rdata[idx];
        err = rs_err[idx];
        break;
      end
    end
    @(posedge clk);
    #1;
    rq_we[idx] = 1'b0;
  endtask

  initial begin
    int lat, stalls, bad;
    logic [31:0] rd, exp_rd;
    logic er;

    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      rq_valid[j] = 1'b0;
      rq_we[j]    = 1'b0;
      rq_addr[j]  = '0;
      rq_be[j]    = '0;
      rq_wdata[j] = '0;
    end

    // Reset state
    #12;
    check("rst_rsp_valid", {31'd0, rs_valid[0]}, 32'd0);
    check("rst_req_ready", {31'd0, rq_ready[0]}, 32'd1);
    check("rst_stall",     {31'd0, rq_stall[0]}, 32'd0);
    check("rst_rdata",     rs_rdata[0], 32'd0);
    check("rst_err",       {31'd0, rs_err[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load, WAIT_CYCLES=2
    issue(0, 1'b1, 9'h010, 4'b1111, 32'hDEADBEEF, lat, stalls, rd, er);
    $display("[TB] store 0x010 <= deadbeef lat=%0d stalls=%0d", lat, stalls);
    check("st_latency", lat, 3);
    check("st_stalls", stalls, 3);
    issue(0, 1'b0, 9'h010, 4'b0000, 32'h0, lat, stalls, rd, er);
    $display("[TB] load 0x010 => %h lat=%0d stalls=%0d", rd, lat, stalls);
    check("ld_latency", lat, 3);
    check("ld_stalls", stalls, 3);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", {31'd0, er}, 32'd0);

    // Byte-enable merge at the top address
    issue(0, 1'b1, 9'h1FF, 4'b1111, 32'h11223344, lat, stalls, rd, er);
    $display("[TB] store 0x1ff <= 11223344 be=1111");
    issue(0, 1'b1, 9'h1FF, 4'b0101, 32'hAABBCCDD, lat, stalls, rd, er);
    $display("[TB] store 0x1ff <= aabbccdd be=0101 held rdata=%h", rd);
    check("rdata_held_over_store", rd, 32'hDEADBEEF);
    issue(0, 1'b0, 9'h1FF, 4'b0000, 32'h0, lat, stalls, rd, er);
    $display("[TB] load 0x1ff => %h", rd);
    check("be_merge", rd, 32'h11BB33DD);

    // Reset mid-WAIT abandons an uncommitted store
    issue(0, 1'b1, 9'h020, 4'b1111, 32'h12345678, lat, stalls, rd, er);
    $display("[TB] store 0x020 <= 12345678");
    rq_valid[0] = 1'b1; rq_we[0] = 1'b1; rq_addr[0] = 9'h020;
    rq_be[0] = 4'b1111; rq_wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    rq_valid[0] = 1'b0; rq_we[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", {31'd0, rq_stall[0]}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rs_valid[0]}, 32'd0);
    check("midrst_rdata", rs_rdata[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rs_valid[0] || rq_stall[0]) bad++;
    end
    @(posedge clk); #1;
    $display("[TB] reset mid-WAIT store cafef00d, stray rsp/stall cycles=%0d", bad);
    check("midrst_quiet_after", bad, 0);
    issue(0, 1'b0, 9'h020, 4'b0000, 32'h0, lat, stalls, rd, er);
    $display("[TB] load 0x020 => %h", rd);
    check("midrst_no_write", rd, 32'h12345678);

    // WAIT_CYCLES=0: preload then back-to-back loads with req_valid held
    issue(1, 1'b1, 9'h003, 4'b1111, 32'h0A0B0C0D, lat, stalls, rd, er);
    $display("[TB] w0 store 0x003 <= 0a0b0c0d lat=%0d stalls=%0d", lat, stalls);
    check("w0_latency", lat, 1);
    check("w0_stalls", stalls, 1);
    issue(1, 1'b1, 9'h004, 4'b1111, 32'h55667788, lat, stalls, rd, er);
    $display("[TB] w0 store 0x004 <= 55667788");
    rq_valid[1] = 1'b1; rq_we[1] = 1'b0; rq_addr[1] = 9'h003;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      $display("[TB] w0 b2b cycle %0d ready=%0b valid=%0b stall=%0b rdata=%h",
               k, rq_ready[1], rs_valid[1], rq_stall[1], rs_rdata[1]);
      check("b2b_ready", {31'd0, rq_ready[1]}, {31'd0, (k % 2 == 0)});
      check("b2b_rsp_valid", {31'd0, rs_valid[1]}, {31'd0, (k % 2 == 1)});
      check("b2b_stall", {31'd0, rq_stall[1]}, {31'd0, (k % 2 == 0)});
      if (k % 2 == 1) begin
        exp_rd = (k == 3) ? 32'h55667788 : 32'h0A0B0C0D;
        check("b2b_rdata", rs_rdata[1], exp_rd);
      end
      @(posedge clk); #1;
      if (k == 0) rq_addr[1] = 9'h004;
      if (k == 2) rq_addr[1] = 9'h003;
    end
    rq_valid[1] = 1'b0;
    @(posedge clk); #1;

    // Parity error injection
    issue(0, 1'b1, 9'h005, 4'b1111, 32'h000000FF, lat, stalls, rd, er);
    $display("[TB] store 0x005 <= 000000ff");
`ifdef DMEM_PARITY_EN
    force dut.par_mem[5] = 4'b0001;
`endif
    issue(0, 1'b0, 9'h005, 4'b0000, 32'h0, lat, stalls, rd, er);
`ifdef DMEM_PARITY_EN
    release dut.par_mem[5];
`endif
    $display("[TB] load 0x005 => %h err=%0b", rd, er);
    check("par_rdata", rd, 32'h000000FF);
`ifdef DMEM_PARITY_EN
    check("par_err", {31'd0, er}, 32'd1);
`else
    check("par_err", {31'd0, er}, 32'd0);
`endif
    check("err_cleared", {31'd0, rs_err[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
